instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage: owns the program counter, drives the word address into the combinational instruction memory and registers the returned 32-bit instruction into an IF/ID output slot with a valid/ready handshake toward decode. Supports stall by back-pressure, redirect from execute (branch/jump), and fault detection on the memory's out-of-range marker word. Sits between the execute-stage redirect logic and the instruction decode stage.

## Interface

Parameters:
- RESET_PC, 64'd0, byte address loaded into the PC on reset.
- IMEM_WORDS, 32, instruction-memory depth in 32-bit words; used only for the `fetch_oob` status.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  word index into instruction memory = pc >> 2 (combinational from pc).
- imem_data  in  32  instruction word returned combinationally for imem_addr; 32'hFFFFFFFF is the out-of-range marker.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  64  byte target address; bits [1:0] ignored (forced to 0).
- out_valid  out  1  IF/ID slot holds an instruction.
- out_ready  in  1  decode accepts the slot this cycle.
- out_instr  out  32  registered instruction.
- out_pc  out  64  byte address of out_instr.
- out_fault  out  1  out_instr is the fault marker (only with FETCH_FAULT_DETECT_EN).
- fetch_halted  out  1  FSM in HALT.
- fetch_oob  out  1  combinational: (pc >> 2) >= IMEM_WORDS.

## Operation

- pc: 64-bit byte address, bits [1:0] always 0; sequential increment +4, wraps modulo 2^64.
- Slot free = !out_valid || out_ready. Load = RUN && slot free && !redirect_valid.
- On load: out_instr <= imem_data, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
- Slot occupied and out_ready=0: pc and slot hold (stall); imem_addr stays stable.
- out_ready with no load (HALT): out_valid <= 0.
- Redirect (highest priority after reset): pc <= {redirect_pc[63:2],2'b00}; out_valid <= 0 (held instruction discarded even if out_ready=1 same cycle — the handshake is treated as not having occurred); out_fault <= 0; FSM -> RUN.
- FSM states: RUN (fetching), HALT (pc frozen, no loads).
  - RUN -> HALT: load of a word with imem_data == 32'hFFFFFFFF while macro enabled; that word is loaded with out_fault=1, pc not incremented.
  - HALT -> RUN: redirect_valid only. Reset -> RUN.
- out_fault follows slot: cleared when slot is emptied or reloaded with a non-fault word.

## Timing

- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_fault=0, FSM=RUN, fetch_halted=0.
- Latency: instruction at pc appears on out_* the cycle after the load edge (1 cycle). First out_valid=1 one cycle after reset deasserts.
- Throughput: 1 instruction/cycle with out_ready held high.
- Redirect penalty: redirect asserted in cycle N -> out_valid=0 in N+1, instruction at redirect_pc valid in N+2.
- Simultaneous redirect + fault word: redirect wins, no HALT.
- Reset mid-stall or mid-HALT: all state returns to reset values next edge; redirect ignored while reset=1.
- out_* stable while out_valid=1 && out_ready=0.

## Configuration

- FETCH_FAULT_DETECT_EN defined: 32'hFFFFFFFF detection, out_fault and HALT state as above.
- Not defined: 32'hFFFFFFFF treated as an ordinary instruction; out_fault tied 0; FSM never leaves RUN; fetch_halted tied 0.

## Test plan

- Reset release with RESET_PC=0, memory words 0x00210783, 0x007782B3, out_ready=1 -> out_pc 0,4 on consecutive cycles with those words; imem_addr 0,1,2.
- out_ready=0 for 3 cycles while out_valid=1 -> out_instr/out_pc/imem_addr unchanged; resumes with next sequential pc on release.
- redirect_valid with redirect_pc=0x13 while slot full and out_ready=1 -> next cycle out_valid=0, pc=0x10; following cycle out_pc=0x10, instr = word 4.
- Run pc to 0x80 (word 32) with macro on -> out_instr=0xFFFFFFFF, out_fault=1, fetch_halted=1, pc stays 0x80, fetch_oob=1; after consumption out_valid=0; redirect to 0 -> RUN, fetch from word 0.
- Same as previous with macro off -> 0xFFFFFFFF delivered with out_fault=0, pc continues to 0x84.
- Assert reset during HALT and during stall -> all outputs at reset values next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, presents the word index
// to a combinational instruction memory, and registers the returned word into
// a single IF/ID slot. The slot talks to decode with a valid/ready handshake.
// Execute can redirect the PC at any time; a redirect flushes the slot.
//
// Optional feature macro: FETCH_FAULT_DETECT_EN
//   defined     : the memory's out-of-range marker word (32'hFFFFFFFF) is
//                 flagged on out_fault and parks the fetcher in HALT until a
//                 redirect arrives.
//   not defined : the marker is an ordinary instruction, out_fault and
//                 fetch_halted stay low, and the FSM never leaves RUN.
//
// Parameters
//   RESET_PC    byte address loaded into the PC on reset (low two bits dropped)
//   IMEM_WORDS  instruction memory depth in words, used only for fetch_oob
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   imem_addr       word index into instruction memory (pc >> 2)
//   imem_data       instruction word for imem_addr (combinational)
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     byte target of the redirect
//   out_valid       IF/ID slot holds an instruction
//   out_ready       decode accepts the slot this cycle
//   out_instr       registered instruction
//   out_pc          byte address of out_instr
//   out_fault       out_instr is the out-of-range marker
//   fetch_halted    fetcher is parked in HALT
//   fetch_oob       current pc lies beyond the instruction memory
//
// FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | fetching; a load happens whenever the slot is free
//   HALT    | marker word was fetched; pc frozen, no loads until redirect
// -----------------------------------------------------------------------------

module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_fault,
  output logic        fetch_halted,
  output logic        fetch_oob
);

  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;
  localparam logic [63:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;
  localparam logic [63:0] IMEM_LIMIT    = 64'(IMEM_WORDS);
  localparam logic [31:0] FAULT_MARKER  = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] pc;
  logic [63:0] redirect_target;
  logic        slot_free;
  logic        load;
  logic        fault_word;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------

  assign imem_addr       = pc >> 2;
  assign fetch_oob       = (imem_addr >= IMEM_LIMIT);
  assign redirect_target = redirect_pc & PC_ALIGN_MASK;

  // The slot can take a new word when it is empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

`ifdef FETCH_FAULT_DETECT_EN
  assign fault_word = (imem_data == FAULT_MARKER);
`else
  assign fault_word = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A redirect always returns to RUN, which also makes it win over a marker
  // word arriving in the same cycle (no load happens during a redirect).
  // ---------------------------------------------------------------------------

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN: begin
        if (redirect_valid) begin
          state_next = ST_RUN;
        end else if (load && fault_word) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------

  always_comb begin
    load = (state == ST_RUN) && slot_free && !redirect_valid;
`ifdef FETCH_FAULT_DETECT_EN
    fetch_halted = (state == ST_HALT);
`else
    fetch_halted = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // PC and IF/ID slot
  // Priority: reset, redirect, load, drain. A redirect discards the slot even
  // when decode raises out_ready in the same cycle. A marker word is loaded
  // but does not advance the pc, so the faulting address stays visible.
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC_AL;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 64'd0;
      out_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= redirect_target;
      out_valid <= 1'b0;
      out_fault <= 1'b0;
    end else if (load) begin
      out_instr <= imem_data;
      out_pc    <= pc;
      out_valid <= 1'b1;
      out_fault <= fault_word;
      if (!fault_word) begin
        pc <= pc + 64'd4;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit with a 32-word combinational memory
// model that returns 32'hFFFFFFFF beyond its last word. A vector table covers
// reset release, streaming, stall, redirect and reset-during-stall; short
// hand-written sequences cover the marker word, HALT, and reset during HALT.
// Expectations for the marker word depend on FETCH_FAULT_DETECT_EN.
// -----------------------------------------------------------------------------

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_fault;
  logic        fetch_halted;
  logic        fetch_oob;

  int tests;
  int fails;

  logic [31:0] mem [32];

  instr_fetch_unit #(
    .RESET_PC   (64'd0),
    .IMEM_WORDS (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .fetch_halted   (fetch_halted),
    .fetch_oob      (fetch_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'd32) imem_data = mem[imem_addr[4:0]];
    else                    imem_data = 32'hFFFF_FFFF;
  end

  function automatic logic [31:0] word(input int i);
    if (i == 0) return 32'h0021_0783;
    if (i == 1) return 32'h0077_82B3;
    return 32'hA000_0000 | 32'(i);
  endfunction

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [63:0] rpc;
    logic        rdy;
    logic        chk_data;
    logic        ev;
    logic [31:0] ei;
    logic [63:0] ep;
    logic [63:0] ea;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdv, input logic [63:0] rpc,
                      input logic rdy);
    reset          = rst;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic chk_data,
                         input logic [31:0] ei, input logic [63:0] ep,
                         input logic [63:0] ea, input logic eh, input logic ef,
                         input logic eo);
    chk({nm, ".valid"}, 64'(out_valid), 64'(ev));
    if (chk_data) begin
      chk({nm, ".instr"}, 64'(out_instr), 64'(ei));
      chk({nm, ".pc"},    out_pc,         ep);
    end
    chk({nm, ".addr"},   imem_addr,         ea);
    chk({nm, ".halted"}, 64'(fetch_halted), 64'(eh));
    chk({nm, ".fault"},  64'(out_fault),    64'(ef));
    chk({nm, ".oob"},    64'(fetch_oob),    64'(eo));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) mem[i] = word(i);

    //          rst  rdv  rpc     rdy  chkd ev    instr     out_pc  imem_addr
    vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 32'h0,    64'h0,  64'd0};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, word(0),  64'h0,  64'd1};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, word(1),  64'h4,  64'd2};
    vecs[3]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, word(1),  64'h4,  64'd2};
    vecs[4]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, word(1),  64'h4,  64'd2};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, word(1),  64'h4,  64'd2};
    vecs[6]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, word(2),  64'h8,  64'd3};
    vecs[7]  = '{1'b0, 1'b1, 64'h13, 1'b1, 1'b0, 1'b0, 32'h0,    64'h0,  64'd4};
    vecs[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, word(4),  64'h10, 64'd5};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, word(4),  64'h10, 64'd5};
    vecs[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 32'h0,    64'h0,  64'd0};
    vecs[11] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, word(0),  64'h0,  64'd1};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].rdv, vecs[v].rpc, vecs[v].rdy);
      chk_all($sformatf("vec%0d", v), vecs[v].ev, vecs[v].chk_data, vecs[v].ei,
              vecs[v].ep, vecs[v].ea, 1'b0, 1'b0, 1'b0);
    end

    // Walk to the last memory word, then into the out-of-range marker.
    step(1'b0, 1'b1, 64'h7C, 1'b1);
    chk_all("to_w31", 1'b0, 1'b0, 32'h0, 64'h0, 64'd31, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("load_w31", 1'b1, 1'b1, word(31), 64'h7C, 64'd32, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
`ifdef FETCH_FAULT_DETECT_EN
    chk_all("marker", 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h80, 64'd32, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("drained", 1'b0, 1'b0, 32'h0, 64'h0, 64'd32, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("halt_hold", 1'b0, 1'b0, 32'h0, 64'h0, 64'd32, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'h40, 1'b1);
    chk_all("rst_halt", 1'b0, 1'b1, 32'h0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Redirect in the same cycle the marker word is presented: no HALT.
    step(1'b0, 1'b1, 64'h7C, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("w31_again", 1'b1, 1'b1, word(31), 64'h7C, 64'd32, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 64'h0, 1'b1);
    chk_all("rdr_vs_fault", 1'b0, 1'b0, 32'h0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("after_rdr", 1'b1, 1'b1, word(0), 64'h0, 64'd1, 1'b0, 1'b0, 1'b0);

    // Halt again, then leave HALT through a redirect to 0.
    step(1'b0, 1'b1, 64'h7C, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("halt2", 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h80, 64'd32, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h0, 1'b1);
    chk_all("exit_halt", 1'b0, 1'b0, 32'h0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("refetch_w0", 1'b1, 1'b1, word(0), 64'h0, 64'd1, 1'b0, 1'b0, 1'b0);
`else
    chk_all("marker", 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h80, 64'd33, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("past_marker", 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h84, 64'd34, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    chk_all("oob_stall", 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h84, 64'd34, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'h40, 1'b0);
    chk_all("rst_stall", 1'b0, 1'b1, 32'h0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk_all("refetch_w0", 1'b1, 1'b1, word(0), 64'h0, 64'd1, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
